// File: rtl/gpio_bank_ctrl.sv
// Register-mapped GPIO bank: synchronised and debounced inputs, atomic output
// set/clear, and per-pin rise/fall interrupts with write-1-to-clear pending bits.
module gpio_bank_ctrl #(
    parameter int unsigned WIDTH           = 14,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bus_valid,
    input  logic             bus_write,
    input  logic [2:0]       bus_addr,
    input  logic [WIDTH-1:0] bus_wdata,
    output logic             bus_rsp_valid,
    output logic [WIDTH-1:0] bus_rdata,
    input  logic [WIDTH-1:0] gpio_read,
    output logic [WIDTH-1:0] gpio_write,
    output logic [WIDTH-1:0] gpio_writeEnable,
    output logic             interrupt
);

    localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        REG_INPUT   = 3'd0,
        REG_OUTPUT  = 3'd1,
        REG_OE      = 3'd2,
        REG_RISE_IE = 3'd3,
        REG_FALL_IE = 3'd4,
        REG_PENDING = 3'd5,
        REG_OUT_SET = 3'd6,
        REG_OUT_CLR = 3'd7
    } reg_addr_e;

    reg_addr_e        addr;
    logic             write_en;
    logic             read_en;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [WIDTH-1:0] stable_q;
    logic [WIDTH-1:0] stable_d_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] oe_q;
    logic [WIDTH-1:0] rise_ie_q;
    logic [WIDTH-1:0] fall_ie_q;
    logic [WIDTH-1:0] pending_q;
    logic [WIDTH-1:0] read_mux;

    assign addr     = reg_addr_e'(bus_addr);
    assign write_en = bus_valid & bus_write;
    assign read_en  = bus_valid & ~bus_write;
    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gpio_read;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    // A pin's counter only runs while its synchronised value disagrees with stable,
    // so any return to the stable level restarts the qualification window.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= '0;
            for (int unsigned p = 0; p < WIDTH; p++) cnt_q[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < WIDTH; p++) begin
                if (sync_out[p] == stable_q[p]) begin
                    cnt_q[p] <= '0;
                end else if (cnt_q[p] == CNT_LAST) begin
                    stable_q[p] <= sync_out[p];
                    cnt_q[p]    <= '0;
                end else begin
                    cnt_q[p] <= cnt_q[p] + CNT_W'(1);
                end
            end
        end
    end

    assign rise = stable_q & ~stable_d_q;
    assign fall = ~stable_q & stable_d_q;
    assign clr  = (write_en && addr == REG_PENDING) ? bus_wdata : '0;

    always_comb begin
        read_mux = '0;
        case (addr)
            REG_INPUT:   read_mux = stable_q;
            REG_OUTPUT:  read_mux = out_q;
            REG_OE:      read_mux = oe_q;
            REG_RISE_IE: read_mux = rise_ie_q;
            REG_FALL_IE: read_mux = fall_ie_q;
            REG_PENDING: read_mux = pending_q;
            default:     read_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_d_q    <= '0;
            pending_q     <= '0;
            out_q         <= '0;
            oe_q          <= '0;
            rise_ie_q     <= '0;
            fall_ie_q     <= '0;
            bus_rsp_valid <= 1'b0;
            bus_rdata     <= '0;
        end else begin
            stable_d_q    <= stable_q;
            // New events are ORed in after the clear so a same-edge set survives.
            pending_q     <= (pending_q & ~clr) | (rise & rise_ie_q) | (fall & fall_ie_q);
            bus_rsp_valid <= read_en;
            if (read_en) bus_rdata <= read_mux;
            if (write_en) begin
                case (addr)
                    REG_OUTPUT:  out_q     <= bus_wdata;
                    REG_OE:      oe_q      <= bus_wdata;
                    REG_RISE_IE: rise_ie_q <= bus_wdata;
                    REG_FALL_IE: fall_ie_q <= bus_wdata;
                    REG_OUT_SET: out_q     <= out_q | bus_wdata;
                    REG_OUT_CLR: out_q     <= out_q & ~bus_wdata;
                    default: ;
                endcase
            end
        end
    end

    assign gpio_write       = out_q;
    assign gpio_writeEnable = oe_q;
    assign interrupt        = |pending_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Directed bench for gpio_bank_ctrl: a behavioural register/debounce model is
// compared every cycle, plus literal expectations along the test sequence.
module tb_gpio_bank_ctrl;

    localparam int unsigned W    = 14;
    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HL   = SYNC + DEB - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         bus_valid;
    logic         bus_write;
    logic [2:0]   bus_addr;
    logic [W-1:0] bus_wdata;
    logic         bus_rsp_valid;
    logic [W-1:0] bus_rdata;
    logic [W-1:0] gpio_read;
    logic [W-1:0] gpio_write;
    logic [W-1:0] gpio_writeEnable;
    logic         interrupt;

    int checks = 0;
    int errors = 0;

    gpio_bank_ctrl #(
        .WIDTH(W),
        .SYNC_STAGES(SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus_valid(bus_valid),
        .bus_write(bus_write),
        .bus_addr(bus_addr),
        .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid),
        .bus_rdata(bus_rdata),
        .gpio_read(gpio_read),
        .gpio_write(gpio_write),
        .gpio_writeEnable(gpio_writeEnable),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model. hist[i] is the pad value sampled i+1 edges ago; a pin's
    // accepted value flips once the last DEB synchronised samples all oppose it.
    logic [W-1:0] hist [$];
    logic [W-1:0] m_out, m_oe, m_rie, m_fie, m_pend, m_stable, m_stable_d, m_rdata;
    logic         m_rsp;
    bit           m_ready = 0;

    always @(posedge clk) begin
        logic [W-1:0] rv, clr, rise, fall, nxt;
        bit all_opp;
        if (reset) begin
            m_out = '0; m_oe = '0; m_rie = '0; m_fie = '0; m_pend = '0;
            m_stable = '0; m_stable_d = '0; m_rdata = '0; m_rsp = 1'b0;
            hist.delete();
            for (int i = 0; i < HL; i++) hist.push_front('0);
            m_ready = 1;
        end else if (m_ready) begin
            rise = m_stable & ~m_stable_d;
            fall = ~m_stable & m_stable_d;
            nxt  = m_stable;
            for (int p = 0; p < W; p++) begin
                all_opp = 1;
                for (int k = 0; k < DEB; k++)
                    if (hist[SYNC-1+k][p] == m_stable[p]) all_opp = 0;
                if (all_opp) nxt[p] = ~m_stable[p];
            end
            case (bus_addr)
                3'd0: rv = m_stable;
                3'd1: rv = m_out;
                3'd2: rv = m_oe;
                3'd3: rv = m_rie;
                3'd4: rv = m_fie;
                3'd5: rv = m_pend;
                default: rv = '0;
            endcase
            clr    = (bus_valid && bus_write && bus_addr == 3'd5) ? bus_wdata : '0;
            m_pend = (m_pend & ~clr) | (rise & m_rie) | (fall & m_fie);
            if (bus_valid && bus_write) begin
                case (bus_addr)
                    3'd1: m_out = bus_wdata;
                    3'd2: m_oe  = bus_wdata;
                    3'd3: m_rie = bus_wdata;
                    3'd4: m_fie = bus_wdata;
                    3'd6: m_out = m_out | bus_wdata;
                    3'd7: m_out = m_out & ~bus_wdata;
                    default: ;
                endcase
            end
            m_rsp = bus_valid && !bus_write;
            if (m_rsp) m_rdata = rv;
            m_stable_d = m_stable;
            m_stable   = nxt;
            hist.push_front(gpio_read);
            void'(hist.pop_back());
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("m_gpio_write", 32'(gpio_write), 32'(m_out));
            check("m_gpio_oe", 32'(gpio_writeEnable), 32'(m_oe));
            check("m_interrupt", 32'(interrupt), 32'(|m_pend));
            check("m_rsp_valid", 32'(bus_rsp_valid), 32'(m_rsp));
            check("m_rdata", 32'(bus_rdata), 32'(m_rdata));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] d);
        bus_valid = 1'b1; bus_write = 1'b1; bus_addr = a; bus_wdata = d;
        @(posedge clk);
        #1;
        bus_valid = 1'b0; bus_write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [W-1:0] exp, input string name);
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = a;
        @(posedge clk);
        #1;
        bus_valid = 1'b0;
        check({name, "_vld"}, 32'(bus_rsp_valid), 32'd1);
        check(name, 32'(bus_rdata), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; bus_valid = 1'b0; bus_write = 1'b0; bus_addr = '0;
        bus_wdata = '0; gpio_read = '0;
        idle(3);
        reset = 1'b0;
        check("rst_oe", 32'(gpio_writeEnable), 32'd0);
        check("rst_irq", 32'(interrupt), 32'd0);
        check("rst_rsp", 32'(bus_rsp_valid), 32'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), '0, "rst_read");

        // Output register, atomic set/clear
        wr(3'd1, 14'h0F0F);
        wr(3'd2, 14'h3FFF);
        wr(3'd6, 14'h3000);
        wr(3'd7, 14'h000F);
        check("out_pins", 32'(gpio_write), 32'h3F00);
        check("oe_pins", 32'(gpio_writeEnable), 32'h3FFF);
        rd(3'd1, 14'h3F00, "rd_output");
        rd(3'd6, 14'h0000, "rd_out_set");
        rd(3'd2, 14'h3FFF, "rd_oe");

        // Pin 3 rises: INPUT changes SYNC+DEB = 6 edges after the first sampling edge
        gpio_read[3] = 1'b1;
        for (int i = 1; i <= 6; i++) rd(3'd0, 14'h0000, "lat_before");
        rd(3'd0, 14'h0008, "lat_after");

        // 3-cycle glitch on pin 5 is filtered
        gpio_read[5] = 1'b1;
        idle(3);
        gpio_read[5] = 1'b0;
        idle(10);
        rd(3'd0, 14'h0008, "glitch");

        // Rise interrupt on pin 3, fall ignored, W1C
        gpio_read[3] = 1'b0;
        idle(10);
        rd(3'd5, 14'h0000, "fall_no_ie");
        wr(3'd3, 14'h0008);
        wr(3'd4, 14'h0000);
        gpio_read[3] = 1'b1;
        idle(6);
        check("irq_before", 32'(interrupt), 32'd0);
        idle(1);
        check("irq_after", 32'(interrupt), 32'd1);
        rd(3'd5, 14'h0008, "pend_rise");
        gpio_read[3] = 1'b0;
        idle(10);
        rd(3'd5, 14'h0008, "pend_after_fall");
        wr(3'd5, 14'h0008);
        check("irq_cleared", 32'(interrupt), 32'd0);

        // New rise on the same edge as W1C: set wins
        gpio_read[3] = 1'b1;
        idle(6);
        wr(3'd5, 14'h0008);
        check("set_wins_irq", 32'(interrupt), 32'd1);
        rd(3'd5, 14'h0008, "set_wins_pend");

        // Reset with a read in flight and PENDING=0x2001
        wr(3'd5, 14'h0008);
        wr(3'd3, 14'h2001);
        gpio_read[0]  = 1'b1;
        gpio_read[13] = 1'b1;
        idle(10);
        rd(3'd5, 14'h2001, "pend_2001");
        check("irq_2001", 32'(interrupt), 32'd1);
        bus_valid = 1'b1; bus_write = 1'b0; bus_addr = 3'd5; reset = 1'b1;
        @(posedge clk);
        #1;
        bus_valid = 1'b0; reset = 1'b0;
        check("mid_rst_rsp", 32'(bus_rsp_valid), 32'd0);
        check("mid_rst_out", 32'(gpio_write), 32'd0);
        check("mid_rst_irq", 32'(interrupt), 32'd0);
        rd(3'd5, 14'h0000, "mid_rst_pend");
        rd(3'd1, 14'h0000, "mid_rst_output");
        idle(10);
        check("no_spurious_irq", 32'(interrupt), 32'd0);
        rd(3'd0, 14'h2009, "input_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
